// File: rtl/amber_ddr_line_sched.sv
// Arbitrates the DDR3 native user port between I-cache line refills and D-cache
// refills/write-throughs; unpacks 128-bit read beats into a per-client 24-bit word stream.
module amber_ddr_line_sched #(
    parameter int USER_DATA_W = 128,
    parameter int ADDR_W      = 32,
    parameter int LINE_WORDS  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init_calib_complete,
    input  logic                     ic_req,
    input  logic [47:0]              ic_addr,
    output logic                     ic_ack,
    output logic                     ic_valid,
    output logic [47:0]              ic_rdata,
    output logic                     ic_last,
    input  logic                     dc_req,
    input  logic [47:0]              dc_addr,
    output logic                     dc_ack,
    output logic                     dc_valid,
    output logic [47:0]              dc_rdata,
    output logic                     dc_last,
    input  logic                     dc_we,
    input  logic [47:0]              dc_wdata,
    output logic                     dc_wack,
    output logic                     cmd_en,
    output logic [2:0]               cmd,
    output logic [ADDR_W-1:0]        addr,
    input  logic                     cmd_ready,
    output logic [USER_DATA_W-1:0]   wr_data,
    output logic                     wr_data_en,
    output logic                     wr_data_end,
    input  logic                     wr_data_rdy,
    output logic [USER_DATA_W/8-1:0] wr_data_mask,
    input  logic [USER_DATA_W-1:0]   rd_data,
    input  logic                     rd_data_valid,
    input  logic                     rd_data_end
);

    localparam int BEATS = LINE_WORDS / 4;
    localparam int BW    = $clog2(BEATS + 1);
    localparam int WW    = BW + 2;
    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam logic [WW-1:0] LAST_WORD = WW'(LINE_WORDS - 1);
    localparam logic [BW-1:0] ALL_BEATS = BW'(BEATS);

    typedef enum logic [2:0] {IDLE, RD_CMD, RD_DATA, WR_CMD, WR_DATA} state_t;

    state_t              state, state_nxt;
    logic                prio_dc;
    logic                client_dc;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          lane_q;
    logic [23:0]         wdata_q;
    logic [BW-1:0]       beat_cnt;
    logic [WW-1:0]       word_cnt;
    logic [23:0]         line_buf [LINE_WORDS];
    logic                ic_valid_q, ic_last_q, dc_valid_q, dc_last_q;
    logic [23:0]         ic_word_q, dc_word_q;

    logic [49:0] ic_line_byte, dc_line_byte, dc_word_byte;
    logic        grant_ok, dc_pending, grant_ic, grant_dcr, grant_dcw;
    logic        beat_in, emit;

    assign ic_line_byte = {ic_addr & ~48'(LINE_WORDS - 1), 2'b00};
    assign dc_line_byte = {dc_addr & ~48'(LINE_WORDS - 1), 2'b00};
    assign dc_word_byte = {dc_addr[47:2], 2'b00, 2'b00};

    // Write-through outranks a D-cache read; the pointer only matters when IC also waits.
    assign grant_ok   = (state == IDLE) && init_calib_complete && !rst;
    assign dc_pending = dc_we || dc_req;
    assign grant_ic   = grant_ok && ic_req && (!dc_pending || !prio_dc);
    assign grant_dcw  = grant_ok && !grant_ic && dc_we;
    assign grant_dcr  = grant_ok && !grant_ic && !dc_we && dc_req;

    assign beat_in = (state == RD_DATA) && rd_data_valid && (beat_cnt != ALL_BEATS);
    assign emit    = (state == RD_DATA) && (word_cnt < {beat_cnt, 2'b00});

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_nxt = state;
        case (state)
            IDLE:    if (grant_ic || grant_dcr) state_nxt = RD_CMD;
                     else if (grant_dcw)        state_nxt = WR_CMD;
            RD_CMD:  if (cmd_ready) state_nxt = RD_DATA;
            RD_DATA: if (emit && word_cnt == LAST_WORD) state_nxt = IDLE;
            WR_CMD:  if (cmd_ready) state_nxt = WR_DATA;
            WR_DATA: if (wr_data_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_data      = '0;
        wr_data_mask = '1;
        if (state == WR_DATA) begin
            wr_data[32*lane_q +: 32]     = {8'b0, wdata_q};
            wr_data_mask[4*lane_q +: 3] = 3'b000;
        end
    end

    assign ic_ack      = grant_ic;
    assign dc_ack      = grant_dcr;
    assign dc_wack     = (state == WR_DATA) && wr_data_rdy;
    assign cmd_en      = (state == RD_CMD) || (state == WR_CMD);
    assign cmd         = (state == RD_CMD) ? 3'b001 : 3'b000;
    assign addr        = cmd_en ? addr_q : '0;
    assign wr_data_en  = (state == WR_DATA);
    assign wr_data_end = (state == WR_DATA);
    assign ic_valid    = ic_valid_q;
    assign ic_last     = ic_last_q;
    assign ic_rdata    = {24'b0, ic_word_q};
    assign dc_valid    = dc_valid_q;
    assign dc_last     = dc_last_q;
    assign dc_rdata    = {24'b0, dc_word_q};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prio_dc    <= 1'b0;
            client_dc  <= 1'b0;
            addr_q     <= '0;
            lane_q     <= '0;
            wdata_q    <= '0;
            beat_cnt   <= '0;
            word_cnt   <= '0;
            ic_valid_q <= 1'b0;
            ic_last_q  <= 1'b0;
            ic_word_q  <= '0;
            dc_valid_q <= 1'b0;
            dc_last_q  <= 1'b0;
            dc_word_q  <= '0;
        end else begin
            state      <= state_nxt;
            ic_valid_q <= 1'b0;
            ic_last_q  <= 1'b0;
            dc_valid_q <= 1'b0;
            dc_last_q  <= 1'b0;
            if (grant_ic || grant_dcr) begin
                client_dc <= grant_dcr;
                prio_dc   <= grant_ic;
                addr_q    <= grant_ic ? ic_line_byte[ADDR_W-1:0] : dc_line_byte[ADDR_W-1:0];
                beat_cnt  <= '0;
                word_cnt  <= '0;
            end
            if (grant_dcw) begin
                client_dc <= 1'b1;
                prio_dc   <= 1'b0;
                addr_q    <= dc_word_byte[ADDR_W-1:0];
                lane_q    <= dc_addr[1:0];
                wdata_q   <= dc_wdata[23:0];
            end
            if (beat_in) beat_cnt <= beat_cnt + 1'b1;
            if (emit) begin
                word_cnt <= word_cnt + 1'b1;
                if (client_dc) begin
                    dc_valid_q <= 1'b1;
                    dc_last_q  <= (word_cnt == LAST_WORD);
                    dc_word_q  <= line_buf[word_cnt[IDX_W-1:0]];
                end else begin
                    ic_valid_q <= 1'b1;
                    ic_last_q  <= (word_cnt == LAST_WORD);
                    ic_word_q  <= line_buf[word_cnt[IDX_W-1:0]];
                end
            end
        end
    end

    // NOTE: the line buffer is not reset; words are only read after being written this line.
    always_ff @(posedge clk) begin
        if (beat_in) begin
            for (int j = 0; j < 4; j++)
                line_buf[IDX_W'({beat_cnt, 2'b00}) + IDX_W'(j)] <= rd_data[32*j +: 24];
        end
    end

    logic unused_bits;
    assign unused_bits = ^{rd_data, rd_data_end, dc_wdata[47:24], ic_line_byte[49:ADDR_W],
                           dc_line_byte[49:ADDR_W], dc_word_byte[49:ADDR_W]};

endmodule

// File: doc/amber_ddr_line_sched.md
Name: amber_ddr_line_sched

Overview:
- Schedules the shared Gowin DDR3 native user interface between I-cache line refills and D-cache refills/write-throughs.
- Issues one read command per 8-word cache line and unpacks 128-bit beats into a 24-bit word stream per client.
- Issues single-beat, byte-masked writes for D-cache write-through.
- Sits between the cache clients and the DDR3 controller, replacing per-word access.

Parameters:
USER_DATA_W, 128, DDR user data width; must be 128. 4 lanes of 32 bits, each holding one 24-bit word in bits [23:0] of the lane.
ADDR_W, 32, DDR byte address width.
LINE_WORDS, 8, words per cache line; must be a multiple of 4. Beats per line = LINE_WORDS/4.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
init_calib_complete  in  1  DDR ready; no grant while low
ic_req  in  1  I-cache line read request (level, held until ic_ack)
ic_addr  in  48  word address, any word within line
ic_ack  out  1  1-cycle grant pulse
ic_valid  out  1  returned word strobe
ic_rdata  out  48  {24'b0, word}
ic_last  out  1  with final ic_valid of line
dc_req  in  1  D-cache line read request (level)
dc_addr  in  48  word address (read or write)
dc_ack  out  1  read grant pulse
dc_valid  out  1  returned word strobe
dc_rdata  out  48  {24'b0, word}
dc_last  out  1  final word of line
dc_we  in  1  write-through request (level, held until dc_wack)
dc_wdata  in  48  bits [23:0] written; [47:24] ignored
dc_wack  out  1  1-cycle pulse when write beat accepted
cmd_en  out  1  command strobe
cmd  out  3  000=WR, 001=RD
addr  out  ADDR_W  DDR byte address
cmd_ready  in  1  command accepted when cmd_en & cmd_ready
wr_data  out  128  write beat
wr_data_en  out  1  write beat valid
wr_data_end  out  1  last write beat
wr_data_rdy  in  1  beat accepted when wr_data_en & wr_data_rdy
wr_data_mask  out  16  1 = byte masked
rd_data  in  128  read beat
rd_data_valid  in  1  read beat strobe
rd_data_end  in  1  last beat of burst

Behaviour:
- Reset:
  - All outputs 0, except wr_data_mask = 16'hFFFF.
  - State IDLE, priority pointer = IC.
- States: IDLE, RD_CMD, RD_DATA, WR_CMD, WR_DATA.
- Grant (IDLE only, init_calib_complete=1):
  - dc_we beats dc_req; DC write/read beats a pending ic_req only when pointer = DC.
  - Pointer flips to the other client after every grant, so IC and DC alternate under contention.
  - Grant cycle: pulse ic_ack or dc_ack (reads; writes ack via dc_wack), latch client, address and data.
- Addresses:
  - Line base word = addr with low log2(LINE_WORDS) bits cleared.
  - DDR addr = (line base word << 2)[ADDR_W-1:0].
  - Write addr = (word addr with bits [1:0] cleared) << 2.
- RD_CMD:
  - cmd=001, addr, cmd_en=1 held until cmd_ready; accept cycle -> RD_DATA.
- RD_DATA:
  - Each rd_data_valid beat k is stored in a line buffer; lane j gives word 4k+j.
  - Words stream to the latched client, one per cycle, in order from the line base (word 0 first).
  - Word n is emitted no earlier than the cycle after its beat is captured.
  - Back-to-back beats must not be lost.
  - *_last is asserted with word LINE_WORDS-1, then -> IDLE.
  - rd_data_end is informational only; the beat count governs completion.
- WR_CMD:
  - cmd=000, cmd_en held until cmd_ready; -> WR_DATA.
- WR_DATA:
  - Lane L = word addr[1:0]; wr_data lane L = {8'b0, dc_wdata[23:0]}, other lanes 0.
  - wr_data_mask = all 1 except bytes 4L..4L+2 = 0.
  - wr_data_en = wr_data_end = 1, held until wr_data_rdy.
  - Accept cycle: dc_wack pulse, -> IDLE.
- rd_data_valid outside RD_DATA (including stale beats after reset) is discarded.
- init_calib_complete falling mid-transaction does not abort the transaction; it only blocks new grants.
- Reset mid-transaction: return to IDLE next cycle; the partial line is not delivered.
- Request throughput:
  - Minimum one IDLE cycle between transactions.
  - A held request re-arbitrates each IDLE cycle.

Test Plan:
- IC refill ic_addr=0x13, DDR returns beats B0 (lanes 0x000001..0x000004) and B1 (0x000005..0x000008) back-to-back -> addr=0x40, cmd=001; ic_valid ×8 with ic_rdata 0x000001..0x000008; ic_last on the 8th; dc_valid never.
- ic_req and dc_req asserted together from reset -> IC granted first, then DC; with both held continuously, grants alternate IC,DC,IC,DC.
- dc_we addr=0x06 wdata=0xABCDEF, wr_data_rdy delayed 3 cycles -> addr=0x10; lane 2 bits [87:64]=0xABCDEF; mask=16'hF8FF; wr_data_en held 4 cycles; single dc_wack.
- dc_we and dc_req both pending, pointer=DC -> write serviced before read.
- cmd_ready low 5 cycles -> cmd_en/addr stable throughout, no ack duplication; init_calib_complete=0 -> no cmd_en at all.
- rst asserted after first beat of a refill -> all outputs reset next cycle; a late second beat produces no valid; the next request completes normally.
